// File: rtl/pll_phase_ctrl.sv
// Drives the ECP5 PLL dynamic phase-shift port and supervises PLL lock.
// Downstream reset is released only after the synchronised lock has been stable long enough.
module pll_phase_ctrl #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STEP_SETUP         = 4,
    parameter int STEP_PULSE         = 4,
    parameter int STEP_GAP           = 8,
    parameter int CNT_W              = 8
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             pll_locked_i,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_sel,
    input  logic             req_dir,
    input  logic [CNT_W-1:0] req_steps,
    output logic [1:0]       phasesel_o,
    output logic             phasedir_o,
    output logic             phasestep_o,
    output logic             phaseloadreg_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             abort_o,
    output logic             lock_ok_o,
    output logic             sys_reset_o
);

    localparam int LCK_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TMR_W = $clog2(STEP_SETUP + STEP_PULSE + STEP_GAP + 1);
    localparam logic [LCK_W-1:0] LOCK_MAX = LCK_W'(LOCK_STABLE_CYCLES);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_IDLE      = 3'd1,
        ST_SETUP     = 3'd2,
        ST_PULSE     = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    logic             lk_meta_q, lk_s_q;
    logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             lock_ok_q, sys_reset_q;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [1:0]       sel_q, sel_d;
    logic             dir_q, dir_d;
    logic             accept_s;

    logic req_ready_q, req_ready_d;
    logic busy_q, busy_d;
    logic step_q, step_d;
    logic done_q, done_d;
    logic abort_q, abort_d;

    // Lock stability counter: counts synced-lock cycles, saturating, cleared by any low sample
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (!lk_s_q) begin
            lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_MAX) begin
            lock_cnt_d = lock_cnt_q;
        end else begin
            lock_cnt_d = lock_cnt_q + LCK_W'(1);
        end
    end

    // Lock synchroniser, stability flag and downstream reset
    always_ff @(posedge clk_i) begin
        if (reset) begin
            lk_meta_q   <= 1'b0;
            lk_s_q      <= 1'b0;
            lock_cnt_q  <= '0;
            lock_ok_q   <= 1'b0;
            sys_reset_q <= 1'b1;
        end else begin
            lk_meta_q   <= pll_locked_i;
            lk_s_q      <= lk_meta_q;
            lock_cnt_q  <= lock_cnt_d;
            lock_ok_q   <= (lock_cnt_d == LOCK_MAX);
            sys_reset_q <= ~lock_ok_q;
        end
    end

    // FSM state, datapath and registered outputs
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q     <= ST_WAIT_LOCK;
            timer_q     <= '0;
            rem_q       <= '0;
            sel_q       <= 2'd0;
            dir_q       <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            step_q      <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            rem_q       <= rem_d;
            sel_q       <= sel_d;
            dir_q       <= dir_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            step_q      <= step_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
        end
    end

    assign accept_s = req_valid & req_ready_q;

    // Next-state logic: lock loss while busy overrides normal sequencing
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_ok_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_IDLE: begin
                if (accept_s) begin
                    sel_d   = req_sel;
                    dir_d   = req_dir;
                    rem_d   = req_steps;
                    timer_d = '0;
                    if (req_steps == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end else if (!lock_ok_q) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (!lock_ok_q) begin
                    state_d = ST_WAIT_LOCK;
                    rem_d   = '0;
                end else if (timer_q == TMR_W'(STEP_SETUP - 1)) begin
                    state_d = ST_PULSE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_PULSE: begin
                if (!lock_ok_q) begin
                    state_d = ST_WAIT_LOCK;
                    rem_d   = '0;
                end else if (timer_q == TMR_W'(STEP_PULSE - 1)) begin
                    state_d = ST_GAP;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_GAP: begin
                if (!lock_ok_q) begin
                    state_d = ST_WAIT_LOCK;
                    rem_d   = '0;
                end else if (timer_q == TMR_W'(STEP_GAP - 1)) begin
                    timer_d = '0;
                    rem_d   = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_PULSE;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                timer_d = '0;
                rem_d   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop
    always_comb begin
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_GAP);
        step_d      = (state_d == ST_PULSE);
        if ((state_q == ST_IDLE) && accept_s && (req_steps == '0)) begin
            done_d = 1'b1;
        end else if ((state_q == ST_GAP) && (state_d == ST_IDLE)) begin
            done_d = 1'b1;
        end else begin
            done_d = 1'b0;
        end
        if (busy_q && (state_d == ST_WAIT_LOCK)) begin
            abort_d = 1'b1;
        end else begin
            abort_d = 1'b0;
        end
    end

    assign req_ready      = req_ready_q;
    assign phasesel_o     = sel_q;
    assign phasedir_o     = dir_q;
    assign phasestep_o    = step_q;
    assign phaseloadreg_o = 1'b0;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign abort_o        = abort_q;
    assign lock_ok_o      = lock_ok_q;
    assign sys_reset_o    = sys_reset_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl: a negedge monitor scores pulse/done timing
// against expectations queued at each accepted request.
module tb_pll_phase_ctrl;

    logic       clk_i = 1'b0;
    logic       reset;
    logic       pll_locked_i;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_sel;
    logic       req_dir;
    logic [7:0] req_steps;
    logic [1:0] phasesel_o;
    logic       phasedir_o, phasestep_o, phaseloadreg_o, busy_o, done_o, abort_o;
    logic       lock_ok_o, sys_reset_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pulse_cnt = 0, done_cnt = 0, abort_cnt = 0, acc_cnt = 0;
    int pulse_q[$];
    int done_q[$];
    int width = 0;
    logic ps_prev = 1'b0;
    logic [1:0] exp_sel = 2'd0;
    logic exp_dir = 1'b0;

    pll_phase_ctrl dut (
        .clk_i          (clk_i),
        .reset          (reset),
        .pll_locked_i   (pll_locked_i),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_sel        (req_sel),
        .req_dir        (req_dir),
        .req_steps      (req_steps),
        .phasesel_o     (phasesel_o),
        .phasedir_o     (phasedir_o),
        .phasestep_o    (phasestep_o),
        .phaseloadreg_o (phaseloadreg_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .abort_o        (abort_o),
        .lock_ok_o      (lock_ok_o),
        .sys_reset_o    (sys_reset_o)
    );

    always #20 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: queue expectations on accept, pop on pulse/done
    always @(negedge clk_i) begin
        if (req_valid && req_ready && !reset) begin
            acc_cnt++;
            exp_sel = req_sel;
            exp_dir = req_dir;
            if (req_steps == 8'd0) begin
                done_q.push_back(cyc + 1);
            end else begin
                for (int i = 0; i < int'(req_steps); i++) pulse_q.push_back(cyc + 5 + i * 12);
                done_q.push_back(cyc + 5 + int'(req_steps) * 12);
            end
        end
        if (phasestep_o && !ps_prev) begin
            pulse_cnt++;
            if (pulse_q.size() == 0) chk("pulse_unexpected", 32'd1, 32'd0);
            else chk("pulse_time", cyc, pulse_q.pop_front());
            chk("pulse_sel", {30'd0, phasesel_o}, {30'd0, exp_sel});
            chk("pulse_dir", {31'd0, phasedir_o}, {31'd0, exp_dir});
        end
        if (phasestep_o) width++;
        if (!phasestep_o && ps_prev) begin
            if (abort_o || reset) chk("pulse_width_cut", {31'd0, (width < 4)}, 32'd1);
            else chk("pulse_width", width, 32'd4);
            width = 0;
        end
        ps_prev = phasestep_o;
        if (done_o) begin
            done_cnt++;
            if (done_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
            else chk("done_time", cyc, done_q.pop_front());
        end
        if (abort_o) abort_cnt++;
    end

    task automatic wait_until(input int c);
        do @(negedge clk_i); while (cyc < c);
    endtask

    task automatic wait_accept(output int k);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!req_ready && n < 2000);
        if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
        k = cyc;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_req(input logic [1:0] s, input logic d, input logic [7:0] n, output int k);
        @(posedge clk_i);
        #1;
        req_sel = s; req_dir = d; req_steps = n; req_valid = 1'b1;
        wait_accept(k);
        req_valid = 1'b0;
    endtask

    initial begin
        int r, k, k2, p0, d0, a0, c0;
        reset = 1'b1; pll_locked_i = 1'b1; req_valid = 1'b0;
        req_sel = 2'd0; req_dir = 1'b0; req_steps = 8'd0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_step", {31'd0, phasestep_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_lock_ok", {31'd0, lock_ok_o}, 32'd0);
        chk("rst_sys_reset", {31'd0, sys_reset_o}, 32'd1);
        chk("rst_done_abort", {30'd0, done_o, abort_o}, 32'd0);
        chk("rst_sel_dir", {29'd0, phasesel_o, phasedir_o}, 32'd0);

        // Lock-up from reset
        @(posedge clk_i); #1; reset = 1'b0; r = cyc;
        wait_until(r + 1025);
        chk("lock_early", {31'd0, lock_ok_o}, 32'd0);
        wait_until(r + 1026);
        chk("lock_rise", {31'd0, lock_ok_o}, 32'd1);
        chk("sysrst_lag", {31'd0, sys_reset_o}, 32'd1);
        wait_until(r + 1027);
        chk("sysrst_fall", {31'd0, sys_reset_o}, 32'd0);
        chk("ready_up", {31'd0, req_ready}, 32'd1);

        // Three steps
        p0 = pulse_cnt; d0 = done_cnt;
        do_req(2'd1, 1'b1, 8'd3, k);
        wait_until(k + 42);
        chk("s3_pulses", pulse_cnt - p0, 32'd3);
        chk("s3_done", done_cnt - d0, 32'd1);
        chk("s3_sel_hold", {30'd0, phasesel_o}, 32'd1);
        chk("s3_ready", {31'd0, req_ready}, 32'd1);

        // Zero steps
        p0 = pulse_cnt; d0 = done_cnt;
        do_req(2'd2, 1'b0, 8'd0, k);
        wait_until(k + 1);
        chk("s0_done", {31'd0, done_o}, 32'd1);
        chk("s0_ready", {31'd0, req_ready}, 32'd1);
        chk("s0_sel", {30'd0, phasesel_o}, 32'd2);
        wait_until(k + 3);
        chk("s0_pulses", pulse_cnt - p0, 32'd0);
        chk("s0_done_cnt", done_cnt - d0, 32'd1);

        // Lock loss during the second pulse of five
        d0 = done_cnt; a0 = abort_cnt;
        do_req(2'd0, 1'b0, 8'd5, k);
        wait_until(k + 15);
        @(posedge clk_i); #1; pll_locked_i = 1'b0;
        wait_until(k + 20);
        chk("ab_abort", {31'd0, abort_o}, 32'd1);
        chk("ab_step", {31'd0, phasestep_o}, 32'd0);
        chk("ab_sysrst", {31'd0, sys_reset_o}, 32'd1);
        chk("ab_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk_i); #1; pll_locked_i = 1'b1;
        pulse_q.delete(); done_q.delete();
        wait_until(k + 40);
        chk("ab_once", abort_cnt - a0, 32'd1);
        chk("ab_no_done", done_cnt - d0, 32'd0);
        chk("ab_not_ready", {31'd0, req_ready}, 32'd0);
        wait_until(k + 1047);
        chk("relock_ok", {31'd0, lock_ok_o}, 32'd1);
        chk("relock_wait", {31'd0, req_ready}, 32'd0);
        wait_until(k + 1048);
        chk("relock_ready", {31'd0, req_ready}, 32'd1);

        // Held request: back-to-back two-step transfers
        p0 = pulse_cnt; d0 = done_cnt; c0 = acc_cnt;
        @(posedge clk_i); #1;
        req_sel = 2'd3; req_dir = 1'b1; req_steps = 8'd2; req_valid = 1'b1;
        wait_accept(k);
        wait_accept(k2);
        req_valid = 1'b0;
        chk("b2b_gap", k2 - k, 32'd29);
        wait_until(k2 + 30);
        chk("b2b_pulses", pulse_cnt - p0, 32'd4);
        chk("b2b_done", done_cnt - d0, 32'd2);
        chk("b2b_accepts", acc_cnt - c0, 32'd2);

        // Reset mid-pulse
        do_req(2'd1, 1'b0, 8'd3, k);
        wait_until(k + 4);
        @(posedge clk_i); #1; reset = 1'b1;
        wait_until(k + 6);
        chk("mr_step", {31'd0, phasestep_o}, 32'd0);
        chk("mr_busy", {31'd0, busy_o}, 32'd0);
        chk("mr_sysrst", {31'd0, sys_reset_o}, 32'd1);
        chk("mr_lock", {31'd0, lock_ok_o}, 32'd0);
        chk("mr_sel", {30'd0, phasesel_o}, 32'd0);
        pulse_q.delete(); done_q.delete();

        // One-cycle lock glitch at count 500
        @(posedge clk_i); #1; reset = 1'b0; r = cyc;
        wait_until(r + 502);
        pll_locked_i = 1'b0;
        wait_until(r + 503);
        pll_locked_i = 1'b1;
        wait_until(r + 1026);
        chk("gl_restart", {31'd0, lock_ok_o}, 32'd0);
        wait_until(r + 1528);
        chk("gl_early", {31'd0, lock_ok_o}, 32'd0);
        wait_until(r + 1529);
        chk("gl_rise", {31'd0, lock_ok_o}, 32'd1);
        chk("loadreg", {31'd0, phaseloadreg_o}, 32'd0);

        chk("pulse_q_empty", pulse_q.size(), 32'd0);
        chk("done_q_empty", done_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
